// File: rtl/fmlarb2_pkg.sv
// Shared FastMemoryLink constants and the master-select type used by the
// two-master FML arbiter.
package fmlarb2_pkg;

    localparam int FML_DW    = 64;
    localparam int FML_SW    = 8;
    localparam int FML_BURST = 4;
    localparam int WCNT_W    = 3;

    typedef enum logic {
        MASTER0 = 1'b0,
        MASTER1 = 1'b1
    } master_t;

    function automatic master_t other_master(input master_t m);
        return (m == MASTER0) ? MASTER1 : MASTER0;
    endfunction

endpackage

// File: rtl/fmlarb2.sv
// Two-master round-robin arbiter in front of hpdmc: the address phase follows
// a registered owner, write data follows the master whose write was accepted.
module fmlarb2
    import fmlarb2_pkg::*;
#(
    parameter int ADR_W  = 26,
    parameter int WDELAY = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic [ADR_W-1:0]  m0_adr,
    input  logic              m0_stb,
    input  logic              m0_we,
    output logic              m0_eack,
    input  logic [FML_SW-1:0] m0_sel,
    input  logic [FML_DW-1:0] m0_di,
    output logic [FML_DW-1:0] m0_do,

    input  logic [ADR_W-1:0]  m1_adr,
    input  logic              m1_stb,
    input  logic              m1_we,
    output logic              m1_eack,
    input  logic [FML_SW-1:0] m1_sel,
    input  logic [FML_DW-1:0] m1_di,
    output logic [FML_DW-1:0] m1_do,

    output logic [ADR_W-1:0]  s_adr,
    output logic              s_stb,
    output logic              s_we,
    input  logic              s_eack,
    output logic [FML_SW-1:0] s_sel,
    output logic [FML_DW-1:0] s_di,
    input  logic [FML_DW-1:0] s_do
);

    master_t             owner;
    master_t             wowner;
    master_t             data_src;
    logic [WCNT_W-1:0]   wcnt;
    logic                own_stb;
    logic                other_stb;

    always_comb begin
        own_stb   = (owner == MASTER1) ? m1_stb : m0_stb;
        other_stb = (owner == MASTER1) ? m0_stb : m1_stb;
    end

    assign s_adr   = (owner == MASTER1) ? m1_adr : m0_adr;
    assign s_stb   = own_stb;
    assign s_we    = (owner == MASTER1) ? m1_we : m0_we;
    assign m0_eack = s_eack & (owner == MASTER0);
    assign m1_eack = s_eack & (owner == MASTER1);

    // Outside a write window the owner's beat passes straight through.
    assign data_src = (wcnt != '0) ? wowner : owner;
    assign s_di     = (data_src == MASTER1) ? m1_di : m0_di;
    assign s_sel    = (data_src == MASTER1) ? m1_sel : m0_sel;

    assign m0_do = s_do;
    assign m1_do = s_do;

    // Owner may only move when the current owner is idle or just got eack,
    // since an FML master holds stb until it is acknowledged.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            owner  <= MASTER0;
            wowner <= MASTER0;
            wcnt   <= '0;
        end else begin
            if (other_stb && (s_eack || !own_stb))
                owner <= other_master(owner);
            if (s_eack && s_we) begin
                wowner <= owner;
                wcnt   <= WCNT_W'(WDELAY + FML_BURST);
            end else if (wcnt != '0) begin
                wcnt <= wcnt - WCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fmlarb2.sv
// Self-checking bench for fmlarb2: directed scenarios plus random traffic
// compared against a cycle-indexed behavioural model of the arbitration rules.
module tb_fmlarb2;
    import fmlarb2_pkg::*;

    localparam int ADR_W = 26;
    localparam int WDELAY = 1;
    localparam logic [ADR_W-1:0] A_ZERO = '0;
    localparam logic [ADR_W-1:0] A_M1 = 26'h0000123;
    localparam logic [ADR_W-1:0] A_HI = 26'h0200000;
    localparam logic [ADR_W-1:0] A_W0 = 26'h0000040;
    localparam logic [ADR_W-1:0] A_W1 = 26'h0000080;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic [ADR_W-1:0] m0_adr, m1_adr, s_adr;
    logic m0_stb, m1_stb, m0_we, m1_we, m0_eack, m1_eack;
    logic s_stb, s_we, s_eack;
    logic [FML_SW-1:0] m0_sel, m1_sel, s_sel;
    logic [FML_DW-1:0] m0_di, m1_di, m0_do, m1_do, s_di, s_do;

    int checks = 0;
    int failures = 0;
    int m_owner;
    int win_master;
    int win_end;
    int cyc;
    bit win_valid;
    bit rand_data;
    bit fair_phase;
    int acc0, acc1, last_acc, consec_viol;

    fmlarb2 #(.ADR_W(ADR_W), .WDELAY(WDELAY)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_we(m0_we), .m0_eack(m0_eack),
        .m0_sel(m0_sel), .m0_di(m0_di), .m0_do(m0_do),
        .m1_adr(m1_adr), .m1_stb(m1_stb), .m1_we(m1_we), .m1_eack(m1_eack),
        .m1_sel(m1_sel), .m1_di(m1_di), .m1_do(m1_do),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_eack(s_eack),
        .s_sel(s_sel), .s_di(s_di), .s_do(s_do)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected combinational outputs for the current cycle from the model state.
    task automatic checkOutput();
        logic [ADR_W-1:0] e_adr;
        logic e_stb, e_we, e_ek0, e_ek1;
        logic [FML_DW-1:0] e_di;
        logic [FML_SW-1:0] e_sel;
        int src;
        e_adr = (m_owner == 1) ? m1_adr : m0_adr;
        e_stb = (m_owner == 1) ? m1_stb : m0_stb;
        e_we  = (m_owner == 1) ? m1_we : m0_we;
        e_ek0 = s_eack && (m_owner == 0);
        e_ek1 = s_eack && (m_owner == 1);
        src   = (win_valid && cyc <= win_end) ? win_master : m_owner;
        e_di  = (src == 1) ? m1_di : m0_di;
        e_sel = (src == 1) ? m1_sel : m0_sel;
        chk("s_adr", 128'(s_adr), 128'(e_adr));
        chk("s_stb_we", 128'({s_stb, s_we}), 128'({e_stb, e_we}));
        chk("m_eack", 128'({m0_eack, m1_eack}), 128'({e_ek0, e_ek1}));
        chk("s_di", 128'(s_di), 128'(e_di));
        chk("s_sel", 128'(s_sel), 128'(e_sel));
        chk("m_do", {m0_do, m1_do}, {s_do, s_do});
    endtask

    task automatic applyStimulus(input logic rst,
                                 input logic s0, input logic w0, input logic [ADR_W-1:0] a0,
                                 input logic s1, input logic w1, input logic [ADR_W-1:0] a1,
                                 input logic ek);
        sys_rst = rst;
        m0_stb = s0; m0_we = w0; m0_adr = a0;
        m1_stb = s1; m1_we = w1; m1_adr = a1;
        s_eack = ek;
        if (rand_data) begin
            m0_di  = {$urandom, $urandom};
            m1_di  = ~m0_di;
            m0_sel = 8'($urandom);
            m1_sel = ~m0_sel;
            s_do   = {$urandom, $urandom};
        end else begin
            m0_di = '0; m1_di = '0; m0_sel = '0; m1_sel = '0; s_do = '0;
        end
        #1;
        checkOutput();
    endtask

    // Advance one clock and apply the arbitration rules to the model.
    task automatic clockTick();
        int other;
        logic own_stb, oth_stb, own_we;
        @(posedge sys_clk);
        if (sys_rst) begin
            m_owner = 0;
            win_valid = 1'b0;
        end else begin
            other   = 1 - m_owner;
            own_stb = (m_owner == 1) ? m1_stb : m0_stb;
            oth_stb = (m_owner == 1) ? m0_stb : m1_stb;
            own_we  = (m_owner == 1) ? m1_we : m0_we;
            if (s_eack) begin
                if (fair_phase && last_acc == m_owner && oth_stb) consec_viol++;
                last_acc = m_owner;
                if (m_owner == 0) acc0++; else acc1++;
                if (own_we) begin
                    win_valid  = 1'b1;
                    win_master = m_owner;
                    win_end    = cyc + WDELAY + FML_BURST;
                end
            end
            if (s_eack && oth_stb) m_owner = other;
            else if (!own_stb && oth_stb) m_owner = other;
        end
        cyc++;
        @(negedge sys_clk);
    endtask

    initial begin
        logic r0, r1, w0, w1, rst;
        logic [ADR_W-1:0] a0, a1;
        bit ek, g0, g1;
        int diff;

        rand_data = 1'b0; fair_phase = 1'b0;
        m_owner = 0; win_valid = 1'b0; win_master = 0; win_end = 0; cyc = 0;
        acc0 = 0; acc1 = 0; last_acc = -1; consec_viol = 0;
        sys_rst = 1'b1; s_eack = 1'b0;
        m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0;
        m0_di = '0; m1_di = '0; m0_sel = '0; m1_sel = '0; s_do = '0;
        @(negedge sys_clk);

        // Reset with all inputs low: every output low; m0_stb passes straight through.
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b0, 1'b0, A_ZERO, 1'b0);
        chk("reset_zero_ctl", 128'({s_adr, s_stb, s_we, m0_eack, m1_eack, s_sel}), 128'(0));
        chk("reset_zero_data", {s_di, m0_do}, 128'(0));
        chk("reset_zero_do1", 128'(m1_do), 128'(0));
        clockTick();
        applyStimulus(1'b1, 1'b1, 1'b0, A_ZERO, 1'b0, 1'b0, A_ZERO, 1'b0);
        chk("reset_m0_stb", 128'(s_stb), 128'(1'b1));
        clockTick();
        rand_data = 1'b1;

        // m1 requesting through reset: idle steal on the first edge after release.
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_M1, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_M1, 1'b0);
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_M1, 1'b0);
        chk("post_reset_stb_idle", 128'(s_stb), 128'(1'b0));
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_M1, 1'b1);
        chk("post_reset_adr", 128'(s_adr), 128'(A_M1));
        chk("post_reset_m1_eack", 128'(m1_eack), 128'(1'b1));
        clockTick();

        // Contention out of reset: m0 write first, m1 read in the following cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b0, 1'b0, A_ZERO, 1'b0);
        clockTick();
        applyStimulus(1'b0, 1'b1, 1'b1, A_ZERO, 1'b1, 1'b0, A_HI, 1'b0);
        chk("cont_first_adr", 128'({s_adr, s_we}), 128'({A_ZERO, 1'b1}));
        clockTick();
        applyStimulus(1'b0, 1'b1, 1'b1, A_ZERO, 1'b1, 1'b0, A_HI, 1'b1);
        chk("cont_m0_eack", 128'({m0_eack, m1_eack}), 128'(2'b10));
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_HI, 1'b0);
        chk("cont_handoff_adr", 128'({s_adr, s_stb, s_we}), 128'({A_HI, 1'b1, 1'b0}));
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_HI, 1'b1);
        chk("cont_m1_eack", 128'({m0_eack, m1_eack}), 128'(2'b01));
        clockTick();

        // Write steering: m0 write data keeps flowing while m1 owns the address phase.
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b0, 1'b0, A_ZERO, 1'b0);
        clockTick();
        applyStimulus(1'b0, 1'b1, 1'b1, A_W0, 1'b1, 1'b1, A_W1, 1'b1);
        chk("steer_m0_eack", 128'(m0_eack), 128'(1'b1));
        clockTick();
        for (int i = 0; i < WDELAY + FML_BURST; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b1, A_W1, 1'b0);
            chk("steer_di", 128'(s_di), 128'(m0_di));
            chk("steer_sel", 128'(s_sel), 128'(m0_sel));
            chk("steer_owner_adr", 128'(s_adr), 128'(A_W1));
            clockTick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b1, A_W1, 1'b0);
        chk("steer_end_di", 128'(s_di), 128'(m1_di));
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b1, A_W1, 1'b1);
        chk("steer_m1_eack", 128'(m1_eack), 128'(1'b1));
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b0, 1'b0, A_W1, 1'b0);
        chk("win_m1_di", 128'(s_di), 128'(m1_di));
        clockTick();

        // Reset inside m1's write window drops the window and the ownership.
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b0, 1'b0, A_W1, 1'b0);
        clockTick();
        applyStimulus(1'b0, 1'b0, 1'b0, A_ZERO, 1'b1, 1'b0, A_W1, 1'b0);
        chk("midrst_di", 128'(s_di), 128'(m0_di));
        chk("midrst_owner", 128'(s_adr), 128'(A_ZERO));
        clockTick();

        // Fairness: both masters request continuously for 200 accepted bursts.
        applyStimulus(1'b1, 1'b0, 1'b0, A_ZERO, 1'b0, 1'b0, A_ZERO, 1'b0);
        clockTick();
        fair_phase = 1'b1; acc0 = 0; acc1 = 0; last_acc = -1; consec_viol = 0;
        w0 = 1'($urandom); a0 = ADR_W'($urandom);
        w1 = 1'($urandom); a1 = ADR_W'($urandom);
        for (int i = 0; i < 4000 && (acc0 + acc1) < 200; i++) begin
            ek = ($urandom_range(0, 2) != 0);
            applyStimulus(1'b0, 1'b1, w0, a0, 1'b1, w1, a1, ek);
            g0 = ek && (m_owner == 0);
            g1 = ek && (m_owner == 1);
            clockTick();
            if (g0) begin w0 = 1'($urandom); a0 = ADR_W'($urandom); end
            if (g1) begin w1 = 1'($urandom); a1 = ADR_W'($urandom); end
        end
        fair_phase = 1'b0;
        diff = (acc0 > acc1) ? acc0 - acc1 : acc1 - acc0;
        chk("fair_done", 128'((acc0 + acc1) >= 200), 128'(1'b1));
        chk("fair_diff", 128'(diff <= 1), 128'(1'b1));
        chk("fair_wait", 128'(consec_viol), 128'(0));

        // Random traffic: sporadic requests held until eack, occasional resets.
        r0 = 1'b0; r1 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!r0 && $urandom_range(0, 2) == 0) begin
                r0 = 1'b1; w0 = 1'($urandom); a0 = ADR_W'($urandom);
            end
            if (!r1 && $urandom_range(0, 2) == 0) begin
                r1 = 1'b1; w1 = 1'($urandom); a1 = ADR_W'($urandom);
            end
            ek = !rst && ((m_owner == 1) ? r1 : r0) && ($urandom_range(0, 1) == 1);
            applyStimulus(rst, r0, w0, a0, r1, w1, a1, ek);
            g0 = ek && (m_owner == 0);
            g1 = ek && (m_owner == 1);
            clockTick();
            if (g0 || rst) r0 = 1'b0;
            if (g1 || rst) r1 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
